// File: rtl/gshare_pkg.sv
// Shared opcode constants, counter encodings and the saturating counter step
// for the gshare branch predictor.
package gshare_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_e;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'b01;
        end
        return (ctr == SNT) ? SNT : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/gshare_pht_ram.sv
// Pattern history table: 2-bit counters, one combinational read port and one
// synchronous write port shared between the init sweep and training updates.
module gshare_pht_ram
    import gshare_pkg::*;
#(
    parameter int          IDX_BITS = 8,
    parameter logic [1:0]  CTR_INIT = WNT
) (
    input  logic                clk,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [1:0]          rd_ctr,
    input  logic                init_en,
    input  logic [IDX_BITS-1:0] init_idx,
    input  logic                upd_en,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0]          mem_q [ENTRIES];
    logic                wr_en_d;
    logic [IDX_BITS-1:0] wr_idx_d;
    logic [1:0]          wr_data_d;

    // The sweep owns the write port; updates only get it once the table is ready.
    always_comb begin
        wr_en_d   = init_en | upd_en;
        wr_idx_d  = upd_idx;
        wr_data_d = ctr_next(mem_q[upd_idx], upd_taken);
        if (init_en) begin
            wr_idx_d  = init_idx;
            wr_data_d = CTR_INIT;
        end
    end

    assign rd_ctr = mem_q[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem_q[wr_idx_d] <= wr_data_d;
        end
    end

endmodule

// File: rtl/gshare_spec_predictor.sv
// gshare direction predictor with speculative global history, per-prediction
// history checkpoints, mispredict recovery and a sequential PHT init sweep.
module gshare_spec_predictor
    import gshare_pkg::*;
#(
    parameter int         PC_BITS  = 32,
    parameter int         IDX_BITS = 8,
    parameter int         GHR_BITS = 8,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic                clk,
    input  logic                rst,
    output logic                pred_ready,
    input  logic                pred_valid,
    input  logic [PC_BITS-1:0]  pred_pc,
    input  logic [6:0]          pred_opcode,
    output logic                pred_taken,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [PC_BITS-1:0]  upd_pc,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_taken,
    input  logic                upd_mispredict
);

    state_e              state_q, state_d;
    logic [IDX_BITS-1:0] init_ptr_q, init_ptr_d;
    logic [GHR_BITS-1:0] ghr_spec_q, ghr_spec_d;
    logic                ready_q, ready_d;

    logic [IDX_BITS-1:0] ghr_spec_ext, upd_ghr_ext;
    logic [IDX_BITS-1:0] pred_idx, upd_idx;
    logic [1:0]          pht_rd_ctr;
    logic                pht_init_en, pht_upd_en;
    logic                is_branch;
    logic                pred_taken_c;

    always_comb begin
        ghr_spec_ext = '0;
        upd_ghr_ext  = '0;
        ghr_spec_ext[GHR_BITS-1:0] = ghr_spec_q;
        upd_ghr_ext[GHR_BITS-1:0]  = upd_ghr;
    end

    assign pred_idx = pred_pc[IDX_BITS+1:2] ^ ghr_spec_ext;
    assign upd_idx  = upd_pc[IDX_BITS+1:2] ^ upd_ghr_ext;

    gshare_pht_ram #(
        .IDX_BITS (IDX_BITS),
        .CTR_INIT (CTR_INIT)
    ) u_pht (
        .clk       (clk),
        .rd_idx    (pred_idx),
        .rd_ctr    (pht_rd_ctr),
        .init_en   (pht_init_en),
        .init_idx  (init_ptr_q),
        .upd_en    (pht_upd_en),
        .upd_idx   (upd_idx),
        .upd_taken (upd_taken)
    );

    // Same-cycle collisions read the pre-update counter: there is no bypass.
    always_comb begin
        is_branch    = (pred_opcode == OPC_BRANCH);
        pred_taken_c = 1'b0;
        if (state_q == S_READY) begin
            if (pred_opcode == OPC_JAL || pred_opcode == OPC_JALR) begin
                pred_taken_c = 1'b1;
            end else if (is_branch) begin
                pred_taken_c = pht_rd_ctr[1];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        ghr_spec_d  = ghr_spec_q;
        ready_d     = ready_q;
        pht_init_en = 1'b0;
        pht_upd_en  = 1'b0;
        case (state_q)
            S_INIT: begin
                pht_init_en = 1'b1;
                init_ptr_d  = init_ptr_q + IDX_BITS'(1);
                if (init_ptr_q == '1) begin
                    state_d = S_READY;
                    ready_d = 1'b1;
                end
            end
            S_READY: begin
                pht_upd_en = upd_valid;
                // Recovery outranks a speculative shift in the same cycle.
                if (upd_valid && upd_mispredict) begin
                    ghr_spec_d = {upd_ghr[GHR_BITS-2:0], upd_taken};
                end else if (pred_valid && is_branch) begin
                    ghr_spec_d = {ghr_spec_q[GHR_BITS-2:0], pred_taken_c};
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_INIT;
            init_ptr_q <= '0;
            ghr_spec_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            ghr_spec_q <= ghr_spec_d;
            ready_q    <= ready_d;
        end
    end

    assign pred_ready = ready_q;
    assign pred_taken = pred_taken_c;
    assign pred_ghr   = ghr_spec_q;

    logic unused_bits;
    assign unused_bits = ^{pred_pc[PC_BITS-1:IDX_BITS+2], pred_pc[1:0],
                           upd_pc[PC_BITS-1:IDX_BITS+2], upd_pc[1:0], pht_rd_ctr[0]};

endmodule

// File: tb/tb_gshare_spec_predictor.sv
// Directed bench for gshare_spec_predictor: init sweep timing, prediction,
// training saturation, speculative history and mispredict recovery.
module tb_gshare_spec_predictor;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ALU    = 7'b0110011;

    logic        clk;
    logic        rst;
    logic        pred_ready;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic [6:0]  pred_opcode;
    logic        pred_taken;
    logic [7:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [7:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;

    int errors = 0;
    int checks = 0;

    gshare_spec_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .pred_ready     (pred_ready),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_opcode    (pred_opcode),
        .pred_taken     (pred_taken),
        .pred_ghr       (pred_ghr),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_ghr        (upd_ghr),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_pred(input logic v, input logic [31:0] pc, input logic [6:0] op);
        pred_valid  = v;
        pred_pc     = pc;
        pred_opcode = op;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic [7:0] g,
                           input logic t, input logic m);
        upd_valid      = v;
        upd_pc         = pc;
        upd_ghr        = g;
        upd_taken      = t;
        upd_mispredict = m;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_pred(1'b0, 32'h0, OP_BRANCH);
        set_upd(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        repeat (3) next_cycle();
        checks++;
        if (pred_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0", pred_ready);
        end
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL reset_taken: got %b expected 0", pred_taken);
        end
        checks++;
        if (pred_ghr !== 8'h00) begin
            errors++; $display("FAIL reset_ghr: got %h expected 00", pred_ghr);
        end
        // Release and run the sweep with a JAL request that must be ignored.
        rst = 1'b0;
        set_pred(1'b1, 32'h100, OP_JAL);
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL init_jal_ignored: got %b expected 0", pred_taken);
        end
        repeat (255) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pred_ready !== 1'b0) begin
            errors++; $display("FAIL sweep_ready_255: got %b expected 0", pred_ready);
        end
        set_pred(1'b0, 32'h0, OP_BRANCH);
        next_cycle();
        checks++;
        if (pred_ready !== 1'b1) begin
            errors++; $display("FAIL sweep_ready_256: got %b expected 1", pred_ready);
        end
        checks++;
        if (pred_ghr !== 8'h00) begin
            errors++; $display("FAIL init_ghr_held: got %h expected 00", pred_ghr);
        end
    endtask

    task automatic test_init_values();
        logic [31:0] pcs [3];
        pcs[0] = 32'h0000_0000;
        pcs[1] = 32'h0000_0040;
        pcs[2] = 32'h0000_03FC;
        for (int i = 0; i < 3; i++) begin
            set_pred(1'b0, pcs[i], OP_BRANCH);
            #1;
            checks++;
            if (pred_taken !== 1'b0) begin
                errors++; $display("FAIL init_branch_pc%0d: got %b expected 0", i, pred_taken);
            end
        end
    endtask

    task automatic test_jumps();
        set_pred(1'b1, 32'h100, OP_JAL);
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            errors++; $display("FAIL jal_taken: got %b expected 1", pred_taken);
        end
        checks++;
        if (pred_ghr !== 8'h00) begin
            errors++; $display("FAIL jal_ghr: got %h expected 00", pred_ghr);
        end
        next_cycle();
        set_pred(1'b1, 32'h104, OP_JALR);
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            errors++; $display("FAIL jalr_taken: got %b expected 1", pred_taken);
        end
        checks++;
        if (pred_ghr !== 8'h00) begin
            errors++; $display("FAIL jal_no_shift: got %h expected 00", pred_ghr);
        end
        next_cycle();
        set_pred(1'b1, 32'h108, OP_ALU);
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL alu_taken: got %b expected 0", pred_taken);
        end
        next_cycle();
        set_pred(1'b0, 32'h0, OP_BRANCH);
        checks++;
        if (pred_ghr !== 8'h00) begin
            errors++; $display("FAIL jalr_alu_no_shift: got %h expected 00", pred_ghr);
        end
    endtask

    task automatic test_train();
        // Index 0x10: 01 -> 10 -> 11.
        set_upd(1'b1, 32'h40, 8'h00, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        set_upd(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        set_pred(1'b1, 32'h40, OP_BRANCH);
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            errors++; $display("FAIL trained_taken: got %b expected 1", pred_taken);
        end
        checks++;
        if (pred_ghr !== 8'h00) begin
            errors++; $display("FAIL trained_ghr: got %h expected 00", pred_ghr);
        end
        next_cycle();
        set_pred(1'b0, 32'h0, OP_BRANCH);
        checks++;
        if (pred_ghr !== 8'h01) begin
            errors++; $display("FAIL spec_shift_taken: got %h expected 01", pred_ghr);
        end
    endtask

    task automatic test_recovery();
        // Recovery and a speculative branch (idx 0x11, predicts 0) in one cycle.
        set_upd(1'b1, 32'h40, 8'h00, 1'b0, 1'b1);
        set_pred(1'b1, 32'h40, OP_BRANCH);
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL recov_pred_taken: got %b expected 0", pred_taken);
        end
        next_cycle();
        set_upd(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        set_pred(1'b0, 32'h40, OP_BRANCH);
        #1;
        checks++;
        if (pred_ghr !== 8'h00) begin
            errors++; $display("FAIL recov_wins: got %h expected 00", pred_ghr);
        end
        checks++;
        if (pred_taken !== 1'b1) begin
            errors++; $display("FAIL recov_pht_10: got %b expected 1", pred_taken);
        end
        // One more not-taken step proves the entry held 10, not 11.
        set_upd(1'b1, 32'h40, 8'h00, 1'b0, 1'b0);
        next_cycle();
        set_upd(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL recov_pht_01: got %b expected 0", pred_taken);
        end
        // Recovery to {5A[6:0],1}; update at idx 0x80^0x5A=0xDA goes 01->10.
        set_upd(1'b1, 32'h200, 8'h5A, 1'b1, 1'b1);
        next_cycle();
        checks++;
        if (pred_ghr !== 8'hB5) begin
            errors++; $display("FAIL recov_load: got %h expected b5", pred_ghr);
        end
        // Correctly predicted update: idx 0x80^0x33=0xB3 goes 01->00, GHR untouched.
        set_upd(1'b1, 32'h200, 8'h33, 1'b0, 1'b0);
        next_cycle();
        set_upd(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (pred_ghr !== 8'hB5) begin
            errors++; $display("FAIL no_mispredict_ghr: got %h expected b5", pred_ghr);
        end
        // Branch at pc 0 hits idx 0xB5 (01): predicts 0, shifts a 0 in.
        set_pred(1'b1, 32'h0, OP_BRANCH);
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL spec_nt_taken: got %b expected 0", pred_taken);
        end
        next_cycle();
        set_pred(1'b0, 32'h0, OP_BRANCH);
        checks++;
        if (pred_ghr !== 8'h6A) begin
            errors++; $display("FAIL spec_shift_nt: got %h expected 6a", pred_ghr);
        end
    endtask

    task automatic test_saturation();
        // GHR is 0x6A: pred pc 0x364 and upd pc 0x2CC/ghr 0 both map to idx 0xB3 (at 00).
        set_pred(1'b0, 32'h364, OP_BRANCH);
        for (int i = 0; i < 4; i++) begin
            set_upd(1'b1, 32'h2CC, 8'h00, 1'b0, 1'b0);
            #1;
            checks++;
            if (pred_taken !== 1'b0) begin
                errors++; $display("FAIL sat_low_%0d: got %b expected 0", i, pred_taken);
            end
            next_cycle();
        end
        // 00,01,10,11,11,11,11 before each taken update.
        for (int i = 0; i < 7; i++) begin
            set_upd(1'b1, 32'h2CC, 8'h00, 1'b1, 1'b0);
            #1;
            checks++;
            if (pred_taken !== (i >= 2)) begin
                errors++; $display("FAIL sat_up_%0d: got %b expected %b", i, pred_taken, (i >= 2));
            end
            next_cycle();
        end
        set_upd(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            errors++; $display("FAIL sat_high: got %b expected 1", pred_taken);
        end
        // Collisions: 11->10 then 10->01, each cycle must see the old counter.
        for (int i = 0; i < 2; i++) begin
            set_upd(1'b1, 32'h2CC, 8'h00, 1'b0, 1'b0);
            #1;
            checks++;
            if (pred_taken !== 1'b1) begin
                errors++; $display("FAIL collide_old_%0d: got %b expected 1", i, pred_taken);
            end
            next_cycle();
        end
        set_upd(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL collide_after: got %b expected 0", pred_taken);
        end
        checks++;
        if (pred_ghr !== 8'h6A) begin
            errors++; $display("FAIL sat_ghr_held: got %h expected 6a", pred_ghr);
        end
    endtask

    task automatic test_reset_mid_sweep();
        // idx 0xDA holds 10; with GHR 0x6A it is reached from pc 0x2C0.
        set_pred(1'b0, 32'h2C0, OP_BRANCH);
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            errors++; $display("FAIL pre_reset_trained: got %b expected 1", pred_taken);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (pred_ready !== 1'b0) begin
            errors++; $display("FAIL async_ready: got %b expected 0", pred_ready);
        end
        checks++;
        if (pred_ghr !== 8'h00) begin
            errors++; $display("FAIL async_ghr: got %h expected 00", pred_ghr);
        end
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL async_taken: got %b expected 0", pred_taken);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (pred_ready !== 1'b0) begin
            errors++; $display("FAIL mid_sweep_ready: got %b expected 0", pred_ready);
        end
        repeat (2) next_cycle();
        rst = 1'b0;
        repeat (255) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pred_ready !== 1'b0) begin
            errors++; $display("FAIL resweep_ready_255: got %b expected 0", pred_ready);
        end
        next_cycle();
        checks++;
        if (pred_ready !== 1'b1) begin
            errors++; $display("FAIL resweep_ready_256: got %b expected 1", pred_ready);
        end
        set_pred(1'b0, 32'h368, OP_BRANCH);
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL cleared_0xDA: got %b expected 0", pred_taken);
        end
        set_pred(1'b0, 32'h40, OP_BRANCH);
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL cleared_0x10: got %b expected 0", pred_taken);
        end
    endtask

    initial begin
        test_reset();
        test_init_values();
        test_jumps();
        test_train();
        test_recovery();
        test_saturation();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gshare_spec_predictor.md
Name: gshare_spec_predictor

Overview:
- Parametrised, clocked gshare branch direction predictor for the fetch/decode stage.
- Keeps a speculative global history register (GHR) that advances at predict time, and hands a GHR checkpoint to the pipeline with every prediction.
- Trains its pattern history table (PHT) at resolve time and restores the GHR on mispredict.
- Clears the PHT with a sequential init sweep instead of a one-cycle array reset.

Parameters:
- PC_BITS, 32, width of fetch/resolve PC.
- IDX_BITS, 8, PHT index width; the PHT has 2^IDX_BITS entries.
- GHR_BITS, 8, history length; must satisfy 2 <= GHR_BITS <= IDX_BITS.
- CTR_INIT, 2'b01, counter value written by the init sweep (weakly not-taken).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pred_ready  out  1  high when the PHT is initialised and predictions/updates are accepted.
- pred_valid  in  1  a prediction request is present this cycle.
- pred_pc  in  PC_BITS  PC of the instruction being predicted.
- pred_opcode  in  7  opcode of the instruction being predicted.
- pred_taken  out  1  predicted direction (combinational).
- pred_ghr  out  GHR_BITS  GHR checkpoint taken before this prediction; travels down the pipe with the instruction.
- upd_valid  in  1  a branch has resolved this cycle.
- upd_pc  in  PC_BITS  PC of the resolved branch.
- upd_ghr  in  GHR_BITS  checkpoint that was returned with that branch's prediction.
- upd_taken  in  1  actual direction of the resolved branch.
- upd_mispredict  in  1  the resolved direction differed from the prediction.

Behaviour:
- Index function:
  - pred_idx = pred_pc[IDX_BITS+1:2] XOR zero-extended ghr_spec.
  - upd_idx = upd_pc[IDX_BITS+1:2] XOR zero-extended upd_ghr.
- FSM has two states, INIT and READY.
- Reset (asynchronous, any time, including mid-sweep):
  - state=INIT, init_ptr=0, ghr_spec=0.
  - pred_ready=0, pred_taken=0, pred_ghr=0.
- INIT:
  - Each cycle: PHT[init_ptr] <= CTR_INIT, then init_ptr increments.
  - After the write to entry 2^IDX_BITS-1, state moves to READY.
  - pred_ready is a registered output; it goes to 1 on the edge that enters READY, so it is high exactly 2^IDX_BITS cycles after reset deassertion.
  - pred_valid and upd_valid are ignored; pred_taken=0.
- Prediction in READY (0-cycle combinational read):
  - pred_taken=1 if pred_opcode is JAL (1101111) or JALR (1100111).
  - Else if pred_opcode is BRANCH (1100011): pred_taken = PHT[pred_idx][1].
  - Else pred_taken=0.
  - pred_ghr = ghr_spec.
- Speculative history:
  - Condition: rising edge with pred_valid=1, state READY and opcode BRANCH.
  - Action: ghr_spec <= {ghr_spec[GHR_BITS-2:0], pred_taken}.
  - JAL, JALR and other opcodes leave the GHR unchanged.
- Update in READY, on a rising edge with upd_valid=1:
  - PHT[upd_idx] saturating increment if upd_taken, saturating decrement otherwise; 11 stays 11, 00 stays 00.
  - Read-modify-write completes in the same cycle.
- Recovery:
  - Condition: upd_valid=1 and upd_mispredict=1.
  - Action: ghr_spec <= {upd_ghr[GHR_BITS-2:0], upd_taken}.
  - Recovery has priority over a same-cycle speculative shift.
- Same-cycle read/write collision: when pred_idx equals upd_idx, the prediction uses the pre-update counter value (no bypass).
- upd_valid=1 with upd_mispredict=0 never modifies ghr_spec.
- Index wrap-around is implicit modulo 2^IDX_BITS.

Decomposition:
- Package gshare_pkg holds:
  - constants OPC_BRANCH, OPC_JAL, OPC_JALR;
  - counter encodings SNT=00, WNT=01, WT=10, ST=11;
  - function ctr_next(ctr, taken) for the saturating step.
- One sub-module, gshare_pht_ram:
  - 2^IDX_BITS x 2-bit array;
  - one combinational read port, one synchronous write port;
  - write-port mux selects the init sweep or the update path.
- The top level holds the FSM, init_ptr, ghr_spec, index hashing and recovery priority.

Test Plan (defaults IDX_BITS=8, GHR_BITS=8):
- Release rst -> pred_ready=0 for 256 cycles, =1 at cycle 256; a BRANCH at any PC then predicts 0 (all entries 01).
- READY, pred_valid with JAL at pc 0x100 -> pred_taken=1, pred_ghr=0x00, ghr_spec stays 0x00 next cycle.
- Two updates: upd_pc=0x40, upd_ghr=0x00, taken=1, mispredict=0 (index 0x10; counter 01->10->11) -> BRANCH predict at 0x40 gives pred_taken=1, pred_ghr=0x00; ghr_spec becomes 0x01 next cycle.
- Next: update upd_pc=0x40, upd_ghr=0x00, taken=0, mispredict=1, in the same cycle as a BRANCH pred_valid -> ghr_spec=0x00 (recovery wins), PHT[0x10]=10.
- Four not-taken updates to an entry at 00 -> stays 00; four taken updates to an entry at 11 -> stays 11; same-cycle predict of that index returns the old value.
- Assert rst at init_ptr=100 -> pred_ready=0 immediately, sweep restarts at 0, pred_ready rises 256 cycles after release; any prior training is cleared to 01.
